wb_rst_seq: RTL and testbench
=============================

WB_RST_SEQ -- requirements
Module: wb_rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of reset channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, async-release synchroniser depth (>=2).
REQ-003 SHALL have parameter STRETCH, default 4, reset stretch length in cycles (>=1).
REQ-004 SHALL have parameter STEP, default 2, cycles between successive channel releases (>=1).
REQ-005 SHALL have port clk_i, input, 1, module clock; the block uses one clock.
REQ-006 SHALL have port async_rst_i, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port sw_rst_req_i, input, 1, software reset request for all channels, sampled on clk_i.
REQ-008 SHALL have port ch_rst_req_i, input, N_CH, per-channel local reset request, sampled on clk_i.
REQ-009 SHALL have port sync_rst_o, output, N_CH, per-channel synchronous reset, active-high.
REQ-010 SHALL have port rst_done_o, output, 1, high once the global release sequence has completed.
REQ-011 SHALL have port rst_cause_o, output, 2, cause of last global reset: 01 async, 10 software.

Function
REQ-012 SHALL assert sync_rst_o to all ones and rst_done_o to 0 immediately (combinationally, no clock) while async_rst_i is high.
REQ-013 SHALL release async_rst_i internally through a SYNC_STAGES-deep synchroniser; assertion asynchronous, deassertion synchronous.
REQ-014 SHALL implement an FSM with states RESET, STRETCH, RELEASE, RUN.
REQ-015 RESET -> STRETCH when synchronised reset falls; STRETCH -> RELEASE after STRETCH cycles; RELEASE -> RUN when channel N_CH-1 is released.
REQ-016 Counting edge 1 as the first rising edge with async_rst_i low, channel i SHALL deassert at edge SYNC_STAGES+STRETCH+i*STEP, channel 0 first, ascending order.
REQ-017 rst_done_o SHALL rise on the same edge as channel N_CH-1 deasserts and stay high in RUN only.
REQ-018 sw_rst_req_i high at edge n in RUN SHALL assert all sync_rst_o and drop rst_done_o after edge n, enter STRETCH, set rst_cause_o=10; channel i deasserts at edge n+STRETCH+i*STEP.
REQ-019 sw_rst_req_i high in STRETCH or RELEASE SHALL re-assert all channels and restart the STRETCH count from edge n; rst_cause_o=10.
REQ-020 ch_rst_req_i[i] high at edge n in RUN SHALL assert sync_rst_o[i] after edge n and deassert at edge n+STRETCH; other channels, rst_done_o and rst_cause_o unaffected.
REQ-021 Per-channel requests SHALL use independent counters; a repeat request on a channel already in local reset restarts its count.
REQ-022 ch_rst_req_i SHALL be ignored outside RUN.
REQ-023 sw_rst_req_i and ch_rst_req_i high on the same edge: software reset wins, local requests dropped.
REQ-024 async_rst_i asserted in any state SHALL abort everything, clear all counters, return to RESET, set rst_cause_o=01.
REQ-025 rst_cause_o SHALL hold its value until the next global reset event.
REQ-026 Counters SHALL be $clog2-sized to hold SYNC_STAGES, STRETCH and (N_CH-1)*STEP+1 without overflow; no wrap-around permitted.

Reset
REQ-027 During async_rst_i: state=RESET, synchroniser all ones, all counters 0, sync_rst_o all ones, rst_done_o=0, rst_cause_o=01.
REQ-028 No output SHALL glitch low during or at the release of async_rst_i.

Structure
REQ-029 Package wb_rst_seq_pkg SHALL hold the FSM state enum and rst_cause_o encodings (CAUSE_ASYNC=01, CAUSE_SW=10).
REQ-030 Synchroniser SHALL be the sub-module wb_rst_sync (parameter SYNC_STAGES, ports clk_i, async_rst_i, sync_rst_o).
REQ-031 Per-channel local-reset counters SHALL be a generate loop over N_CH, not a sub-module.

Verification (N_CH=3, SYNC_STAGES=2, STRETCH=4, STEP=2)
REQ-032 Power-up: async_rst_i low before edge 1 -> sync_rst_o[0] low at edge 6, [1] at 8, [2] at 10; rst_done_o high at 10; rst_cause_o=01.
REQ-033 SW reset: sw_rst_req_i pulse at edge 20 in RUN -> sync_rst_o=111 after 20, channels release at 24, 26, 28; rst_cause_o=10.
REQ-034 Local reset: ch_rst_req_i=010 at edge 30 -> sync_rst_o=010 from 30 to 34; rst_done_o stays 1; repeat at 32 extends release to 36.
REQ-035 Collision: sw_rst_req_i and ch_rst_req_i=001 at edge 40 -> full global sequence as REQ-033 from edge 40; local request has no extra effect.
REQ-036 Mid-sequence async: async_rst_i pulsed between edges 7 and 8 of power-up -> sync_rst_o=111 immediately, sequence restarts from REQ-032 timing, rst_cause_o=01.
REQ-037 Bench SHALL check sync_rst_o never deasserts out of channel order and never glitches during async_rst_i.

Source files
------------

// File: rtl/wb_rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
//   state_e     : sequencer FSM states
//   CAUSE_*     : encodings reported on rst_cause_o
//   cnt_width() : width of the shared sequencing counter
package wb_rst_seq_pkg;

    typedef enum logic [1:0] {
        StReset   = 2'd0,
        StStretch = 2'd1,
        StRelease = 2'd2,
        StRun     = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_ASYNC = 2'b01;
    localparam logic [1:0] CAUSE_SW    = 2'b10;

    // Bits needed to hold the largest of the three values without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/wb_rst_sync.sv
// Reset synchroniser: asynchronous assertion, synchronous deassertion.
//   clk_i       : clock
//   async_rst_i : asynchronous active-high reset in
//   sync_rst_o  : reset out, falls SYNC_STAGES edges after async_rst_i drops
module wb_rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic async_rst_i,
    output logic sync_rst_o
);

    logic [SYNC_STAGES-1:0] stage_q;

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            stage_q <= '1;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/wb_rst_seq.sv
// Reset sequencer: synchronises an external reset, stretches it, then
// releases N_CH channel resets in ascending order STEP cycles apart.
// Supports a global software reset and per-channel local resets in RUN.
//   clk_i        : clock
//   async_rst_i  : asynchronous active-high reset
//   sw_rst_req_i : software reset request (all channels)
//   ch_rst_req_i : per-channel local reset request (honoured in RUN only)
//   sync_rst_o   : per-channel active-high synchronous reset
//   rst_done_o   : high while the global release sequence is complete
//   rst_cause_o  : cause of last global reset (CAUSE_ASYNC / CAUSE_SW)
module wb_rst_seq
    import wb_rst_seq_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH     = 4,
    parameter int unsigned STEP        = 2
) (
    input  logic            clk_i,
    input  logic            async_rst_i,
    input  logic            sw_rst_req_i,
    input  logic [N_CH-1:0] ch_rst_req_i,
    output logic [N_CH-1:0] sync_rst_o,
    output logic            rst_done_o,
    output logic [1:0]      rst_cause_o
);

    localparam int unsigned CNT_W    = cnt_width(SYNC_STAGES, STRETCH, (N_CH - 1) * STEP + 1);
    localparam int unsigned LOC_W    = $clog2(STRETCH + 1);
    // Counter value in RELEASE on the edge that frees the last channel.
    localparam int unsigned REL_LAST = (N_CH > 1) ? (N_CH - 1) * STEP - 1 : 0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   stretch_cur;
    logic [1:0]         cause_q, cause_d;
    logic               rst_sync;
    logic               stretch_adv;
    logic               sw_take;

    wb_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (clk_i),
        .async_rst_i (async_rst_i),
        .sync_rst_o  (rst_sync)
    );

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= StReset;
            cnt_q   <= '0;
            cause_q <= CAUSE_ASYNC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        stretch_adv = 1'b0;
        sw_take     = 1'b0;
        // RESET leaves on the edge after the synchroniser falls, i.e. one
        // stretch cycle has already elapsed, so it advances from count 0.
        stretch_cur = (state_q == StStretch) ? cnt_q : '0;

        unique case (state_q)
            StReset: begin
                stretch_adv = ~rst_sync;
            end
            StStretch: begin
                if (sw_rst_req_i) sw_take = 1'b1;
                else              stretch_adv = 1'b1;
            end
            StRelease: begin
                if (sw_rst_req_i) begin
                    sw_take = 1'b1;
                end else if (cnt_q == CNT_W'(REL_LAST)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
                sw_take = sw_rst_req_i;
            end
            default: begin
                state_d = StReset;
            end
        endcase

        if (stretch_adv) begin
            if (stretch_cur == CNT_W'(STRETCH - 1)) begin
                state_d = (N_CH > 1) ? StRelease : StRun;
                cnt_d   = '0;
            end else begin
                state_d = StStretch;
                cnt_d   = stretch_cur + CNT_W'(1);
            end
        end

        if (sw_take) begin
            state_d = StStretch;
            cnt_d   = '0;
            cause_d = CAUSE_SW;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam int unsigned REL_AT = i * STEP;

        logic [LOC_W-1:0] loc_q;
        logic             released;
        logic             glob_rst;

        // Local reset countdown; a software reset in RUN wins and drops it.
        always_ff @(posedge clk_i or posedge async_rst_i) begin
            if (async_rst_i) begin
                loc_q <= '0;
            end else if (state_q == StRun && sw_rst_req_i) begin
                loc_q <= '0;
            end else if (state_q == StRun && ch_rst_req_i[i]) begin
                loc_q <= LOC_W'(STRETCH);
            end else if (loc_q != '0) begin
                loc_q <= loc_q - LOC_W'(1);
            end
        end

        if (i == 0) begin : g_first
            assign released = 1'b1;
        end else begin : g_rest
            assign released = (cnt_q >= CNT_W'(REL_AT));
        end

        always_comb begin
            glob_rst = 1'b1;
            case (state_q)
                StRelease: glob_rst = ~released;
                StRun:     glob_rst = 1'b0;
                default:   glob_rst = 1'b1;
            endcase
        end

        // async_rst_i is ORed in so the output rises without waiting on any flop.
        assign sync_rst_o[i] = async_rst_i | glob_rst | (loc_q != '0);
    end

    assign rst_done_o  = (state_q == StRun) & ~async_rst_i;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_wb_rst_seq.sv
module tb_wb_rst_seq;

    typedef struct {
        int         edge_no;
        logic [2:0] rst;
        logic       done;
        logic [1:0] cause;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       async_rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [2:0] ch_rst_req = 3'b000;
    logic [2:0] sync_rst;
    logic       rst_done;
    logic [1:0] rst_cause;

    int   tests = 0;
    int   fails = 0;
    int   edge_no = 0;
    exp_t q[$];
    logic [2:0] prev_rst = 3'b111;

    // Hand-computed power-up timeline (edge 1 = first edge with reset low).
    int         pu_edge[8] = '{1, 5, 6, 7, 8, 9, 10, 11};
    logic [2:0] pu_rst[8]  = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000};
    logic       pu_done[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    wb_rst_seq #(
        .N_CH        (3),
        .SYNC_STAGES (2),
        .STRETCH     (4),
        .STEP        (2)
    ) dut (
        .clk_i        (clk),
        .async_rst_i  (async_rst),
        .sw_rst_req_i (sw_rst_req),
        .ch_rst_req_i (ch_rst_req),
        .sync_rst_o   (sync_rst),
        .rst_done_o   (rst_done),
        .rst_cause_o  (rst_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge async_rst) begin
        if (async_rst) edge_no <= 0;
        else           edge_no <= edge_no + 1;
    end

    // Scoreboard monitor: compare when the front expectation's edge is reached.
    always @(negedge clk) begin
        if (!async_rst && q.size() > 0) begin
            if (q[0].edge_no == edge_no) begin
                exp_t x;
                x = q.pop_front();
                tests++;
                if ({sync_rst, rst_done, rst_cause} !== {x.rst, x.done, x.cause}) begin
                    fails++;
                    $display("FAIL %s @edge %0d: got rst=%b done=%b cause=%b, want rst=%b done=%b cause=%b",
                             x.name, edge_no, sync_rst, rst_done, rst_cause, x.rst, x.done, x.cause);
                end
            end
        end
    end

    // Channel-order and reset-glitch watcher.
    always @(negedge clk) begin
        if (async_rst) begin
            tests++;
            if (sync_rst !== 3'b111 || rst_done !== 1'b0) begin
                fails++;
                $display("FAIL glitch: got rst=%b done=%b, want rst=111 done=0", sync_rst, rst_done);
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (prev_rst[j] && !sync_rst[j]) begin
                    logic [2:0] mask;
                    mask = 3'((1 << j) - 1);
                    tests++;
                    if ((sync_rst & mask) != 3'b000) begin
                        fails++;
                        $display("FAIL order: ch%0d released with rst=%b, want lower channels 0", j,
                                 sync_rst);
                    end
                end
            end
        end
        prev_rst = sync_rst;
    end

    task automatic expect_at(input int e, input logic [2:0] r, input logic d,
                             input logic [1:0] c, input string nm);
        exp_t x;
        x.edge_no = e;
        x.rst     = r;
        x.done    = d;
        x.cause   = c;
        x.name    = nm;
        q.push_back(x);
    endtask

    task automatic push_powerup(input int upto, input string nm);
        for (int k = 0; k < 8; k++) begin
            if (pu_edge[k] <= upto) expect_at(pu_edge[k], pu_rst[k], pu_done[k], 2'b01, nm);
        end
    endtask

    task automatic check_now(input string nm, input logic [4:0] got, input logic [4:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got {rst,done,cause}=%b, want %b", nm, got, want);
        end
    endtask

    task automatic wait_edge(input int n);
        int k;
        k = 0;
        while (edge_no != n && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (edge_no != n) begin
            tests++;
            fails++;
            $display("FAIL wait_edge: at edge %0d, want %0d", edge_no, n);
        end
    endtask

    // Hold the request inputs across edge n only.
    task automatic drive_at(input int n, input logic sw, input logic [2:0] ch);
        wait_edge(n - 1);
        sw_rst_req = sw;
        ch_rst_req = ch;
        @(posedge clk);
        #1;
        sw_rst_req = 1'b0;
        ch_rst_req = 3'b000;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_now("reset_state", {sync_rst, rst_done, rst_cause}, {3'b111, 1'b0, 2'b01});

        // Power-up release.
        push_powerup(11, "powerup");
        async_rst = 1'b0;

        // Software reset from RUN.
        expect_at(20, 3'b111, 1'b0, 2'b10, "sw_assert");
        expect_at(23, 3'b111, 1'b0, 2'b10, "sw_stretch");
        expect_at(24, 3'b110, 1'b0, 2'b10, "sw_ch0");
        expect_at(25, 3'b110, 1'b0, 2'b10, "sw_ch0_hold");
        expect_at(26, 3'b100, 1'b0, 2'b10, "sw_ch1");
        expect_at(27, 3'b100, 1'b0, 2'b10, "sw_ch1_hold");
        expect_at(28, 3'b000, 1'b1, 2'b10, "sw_done");
        drive_at(20, 1'b1, 3'b000);

        // Local reset on ch1, re-requested at 32.
        expect_at(30, 3'b010, 1'b1, 2'b10, "loc_assert");
        expect_at(31, 3'b010, 1'b1, 2'b10, "loc_hold");
        expect_at(33, 3'b010, 1'b1, 2'b10, "loc_repeat");
        expect_at(34, 3'b010, 1'b1, 2'b10, "loc_extended");
        expect_at(35, 3'b010, 1'b1, 2'b10, "loc_extended2");
        expect_at(36, 3'b000, 1'b1, 2'b10, "loc_release");
        drive_at(30, 1'b0, 3'b010);
        drive_at(32, 1'b0, 3'b010);

        // Collision, then a local request in RELEASE that must be ignored.
        expect_at(40, 3'b111, 1'b0, 2'b10, "col_assert");
        expect_at(43, 3'b111, 1'b0, 2'b10, "col_stretch");
        expect_at(44, 3'b110, 1'b0, 2'b10, "col_ch0");
        expect_at(46, 3'b100, 1'b0, 2'b10, "col_ch1");
        expect_at(48, 3'b000, 1'b1, 2'b10, "col_done");
        expect_at(49, 3'b000, 1'b1, 2'b10, "col_run");
        drive_at(40, 1'b1, 3'b001);
        drive_at(45, 1'b0, 3'b100);

        // Software reset repeated during STRETCH restarts the count.
        expect_at(50, 3'b111, 1'b0, 2'b10, "restart_assert");
        expect_at(52, 3'b111, 1'b0, 2'b10, "restart_again");
        expect_at(55, 3'b111, 1'b0, 2'b10, "restart_stretch");
        expect_at(56, 3'b110, 1'b0, 2'b10, "restart_ch0");
        expect_at(58, 3'b100, 1'b0, 2'b10, "restart_ch1");
        expect_at(60, 3'b000, 1'b1, 2'b10, "restart_done");
        drive_at(50, 1'b1, 3'b000);
        drive_at(52, 1'b1, 3'b000);

        // Async abort during a software sequence.
        expect_at(70, 3'b111, 1'b0, 2'b10, "pre_abort");
        drive_at(70, 1'b1, 3'b000);
        wait_edge(72);
        async_rst = 1'b1;
        #1;
        check_now("async_abort", {sync_rst, rst_done, rst_cause}, {3'b111, 1'b0, 2'b01});
        repeat (2) @(negedge clk);
        push_powerup(7, "repowerup");
        async_rst = 1'b0;

        // Async pulse between power-up edges 7 and 8.
        wait_edge(7);
        #1;
        async_rst = 1'b1;
        #1;
        check_now("async_mid", {sync_rst, rst_done, rst_cause}, {3'b111, 1'b0, 2'b01});
        #1;
        push_powerup(11, "mid_restart");
        async_rst = 1'b0;
        wait_edge(12);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: expectation for edge %0d never checked", x.name, x.edge_no);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
